// File: rtl/cache_miss_ctrl.sv
// Miss-handling stage: stalls the pipeline on a tag miss, writes back a dirty
// victim line as a beat burst, then fills the requested line from memory.
module cache_miss_ctrl #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic              hit_i,
  input  logic              dirty_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wb_addr_i,
  input  logic [LINE_W-1:0] victim_data_i,
  output logic              stall_o,
  output logic              fill_valid_o,
  output logic [LINE_W-1:0] fill_data_o,
  output logic [31:0]       mem_addr_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [BEAT_W-1:0] mem_wdata_o,
  input  logic [BEAT_W-1:0] mem_rdata_i,
  input  logic              mem_resp_i,
  output logic [31:0]       miss_cnt_o,
  output logic [31:0]       wb_cnt_o
);

  // LINE_W must be a whole multiple of BEAT_W.
  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;
  typedef logic [BEATS-1:0][BEAT_W-1:0] line_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [26:0]      req_line_q, req_line_d;
  logic [26:0]      wb_line_q, wb_line_d;
  line_t            victim_q, victim_d;
  line_t            fill_q, fill_d;
  logic [31:0]      miss_cnt_q, miss_cnt_d;
  logic [31:0]      wb_cnt_q, wb_cnt_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;
  logic             fill_valid_q, fill_valid_d;
  logic             miss;

  // Line offset bits never reach the memory bus.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{addr_i[4:0], wb_addr_i[4:0]};

  assign miss = req_valid_i & ~hit_i;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_line_d = req_line_q;
    wb_line_d  = wb_line_q;
    victim_d   = victim_q;
    fill_d     = fill_q;
    miss_cnt_d = miss_cnt_q;
    wb_cnt_d   = wb_cnt_q;

    case (state_q)
      IDLE: begin
        if (miss) begin
          req_line_d = addr_i[31:5];
          wb_line_d  = wb_addr_i[31:5];
          victim_d   = victim_data_i;
          cnt_d      = '0;
          miss_cnt_d = sat_inc(miss_cnt_q);
          state_d    = dirty_i ? WB : FILL;
        end
      end
      WB: begin
        if (mem_resp_i) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d    = '0;
            wb_cnt_d = sat_inc(wb_cnt_q);
            state_d  = FILL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FILL: begin
        if (mem_resp_i) begin
          fill_d[cnt_q] = mem_rdata_i;
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Bus strobes are registered from the next state so they align with it.
    mem_read_d   = (state_d == FILL);
    mem_write_d  = (state_d == WB);
    fill_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: line buffers are reset too, so fill_data_o starts at 0 and the
      // write-data bus never carries X outside a burst.
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_line_q   <= '0;
      wb_line_q    <= '0;
      victim_q     <= '0;
      fill_q       <= '0;
      miss_cnt_q   <= '0;
      wb_cnt_q     <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      fill_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_line_q   <= req_line_d;
      wb_line_q    <= wb_line_d;
      victim_q     <= victim_d;
      fill_q       <= fill_d;
      miss_cnt_q   <= miss_cnt_d;
      wb_cnt_q     <= wb_cnt_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      fill_valid_q <= fill_valid_d;
    end
  end

  // Stall drops in DONE so upstream advances while the array is written.
  assign stall_o      = (state_q == WB) || (state_q == FILL) || ((state_q == IDLE) && miss);
  assign fill_valid_o = fill_valid_q;
  assign fill_data_o  = fill_q;
  assign mem_read_o   = mem_read_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = (state_q == WB) ? {wb_line_q, 5'b0} : {req_line_q, 5'b0};
  assign mem_wdata_o  = victim_q[cnt_q];
  assign miss_cnt_o   = miss_cnt_q;
  assign wb_cnt_o     = wb_cnt_q;

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Self-checking bench for cache_miss_ctrl: a cycle table for the clean miss,
// then directed sequences for hits, writeback, wait states, reset and back-to-back.
module tb_cache_miss_ctrl;

  logic         clk;
  logic         rst;
  logic         req_valid_i;
  logic         hit_i;
  logic         dirty_i;
  logic [31:0]  addr_i;
  logic [31:0]  wb_addr_i;
  logic [255:0] victim_data_i;
  logic         stall_o;
  logic         fill_valid_o;
  logic [255:0] fill_data_o;
  logic [31:0]  mem_addr_o;
  logic         mem_read_o;
  logic         mem_write_o;
  logic [63:0]  mem_wdata_o;
  logic [63:0]  mem_rdata_i;
  logic         mem_resp_i;
  logic [31:0]  miss_cnt_o;
  logic [31:0]  wb_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_miss = 0;
  int exp_wb   = 0;

  cache_miss_ctrl #(.LINE_W(256), .BEAT_W(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid_i),
    .hit_i         (hit_i),
    .dirty_i       (dirty_i),
    .addr_i        (addr_i),
    .wb_addr_i     (wb_addr_i),
    .victim_data_i (victim_data_i),
    .stall_o       (stall_o),
    .fill_valid_o  (fill_valid_o),
    .fill_data_o   (fill_data_o),
    .mem_addr_o    (mem_addr_o),
    .mem_read_o    (mem_read_o),
    .mem_write_o   (mem_write_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_rdata_i   (mem_rdata_i),
    .mem_resp_i    (mem_resp_i),
    .miss_cnt_o    (miss_cnt_o),
    .wb_cnt_o      (wb_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One memory beat with up to max_wait stall cycles before the response.
  task automatic beat(input logic wr, input logic [31:0] maddr, input logic [63:0] wdat,
                      input logic [63:0] rdat, input int max_wait, input string tag);
    int w;
    w = (max_wait > 0) ? int'($urandom_range(0, max_wait)) : 0;
    for (int k = 0; k <= w; k++) begin
      mem_resp_i  = (k == w);
      mem_rdata_i = (k == w) ? rdat : 64'hBAD0_BAD0_BAD0_BAD0;
      @(negedge clk);
      check({tag, "_ctl"}, {stall_o, mem_read_o, mem_write_o}, {1'b1, ~wr, wr});
      check({tag, "_addr"}, mem_addr_o, maddr);
      if (wr) check({tag, "_wdata"}, mem_wdata_o, wdat);
      check({tag, "_fv"}, fill_valid_o, 1'b0);
      tick();
    end
    mem_resp_i = 1'b0;
  endtask

  // Full miss from the IDLE cycle through DONE; returns at the cycle after DONE.
  task automatic run_miss(input logic [31:0] a, input logic d, input logic [31:0] wa,
                          input logic [255:0] vic, input logic [255:0] fill,
                          input int max_wait, input string tag);
    logic [255:0] v;
    logic [255:0] f;
    v = vic;
    f = fill;
    req_valid_i = 1'b1; hit_i = 1'b0; dirty_i = d;
    addr_i = a; wb_addr_i = wa; victim_data_i = vic; mem_resp_i = 1'b0;
    @(negedge clk);
    check({tag, "_miss_stall"}, stall_o, 1'b1);
    tick();
    exp_miss++;
    // Scramble inputs: the latched miss must not notice.
    hit_i = 1'b1; dirty_i = ~d; addr_i = ~a; wb_addr_i = ~wa; victim_data_i = ~vic;
    if (d) begin
      for (int b = 0; b < 4; b++)
        beat(1'b1, {wa[31:5], 5'b0}, v[b*64 +: 64], 64'h0, max_wait, {tag, "_wb"});
      exp_wb++;
    end
    for (int b = 0; b < 4; b++)
      beat(1'b0, {a[31:5], 5'b0}, 64'h0, f[b*64 +: 64], max_wait, {tag, "_fill"});
    mem_resp_i = 1'b1;
    mem_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    check({tag, "_done_ctl"}, {fill_valid_o, stall_o, mem_read_o, mem_write_o}, 4'b1000);
    check({tag, "_done_data"}, fill_data_o, fill);
    check({tag, "_miss_cnt"}, miss_cnt_o, 32'(exp_miss));
    check({tag, "_wb_cnt"}, wb_cnt_o, 32'(exp_wb));
    tick();
    req_valid_i = 1'b0; hit_i = 1'b0; mem_resp_i = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, "_idle"}, {fill_valid_o, stall_o, mem_read_o, mem_write_o}, 4'b0000);
    tick();
  endtask

  typedef struct {
    logic        req, hit, dirty, resp;
    logic [31:0] addr;
    logic [63:0] rdata;
    logic        stall, rd, wr, fv;
    logic [31:0] maddr;
  } vec_t;

  vec_t vecs [7];

  localparam logic [255:0] FILL_A = {64'hA3, 64'hA2, 64'hA1, 64'hA0};

  initial begin
    // Clean read miss, zero-wait memory; cycle 0 is the miss cycle.
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_1234, 64'h99, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 64'hA0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_1220};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 64'hA1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_1220};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 64'hA2, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_1220};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 64'hA3, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_1220};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         64'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         64'hEE, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};

    rst = 1'b1; req_valid_i = 1'b0; hit_i = 1'b0; dirty_i = 1'b0;
    addr_i = 32'h0; wb_addr_i = 32'h0; victim_data_i = '0;
    mem_rdata_i = 64'h0; mem_resp_i = 1'b0;
    tick(); tick();
    rst = 1'b0;

    @(negedge clk);
    check("rst_ctl", {fill_valid_o, stall_o, mem_read_o, mem_write_o}, 4'b0000);
    check("rst_fill_data", fill_data_o, '0);
    check("rst_counters", {miss_cnt_o, wb_cnt_o}, 64'h0);
    check("rst_addr_known", $isunknown({mem_addr_o, mem_wdata_o}), 1'b0);
    tick();

    for (int i = 0; i < 7; i++) begin
      req_valid_i = vecs[i].req; hit_i = vecs[i].hit; dirty_i = vecs[i].dirty;
      mem_resp_i = vecs[i].resp; addr_i = vecs[i].addr; mem_rdata_i = vecs[i].rdata;
      @(negedge clk);
      check($sformatf("vec%0d_stall", i), stall_o, vecs[i].stall);
      check($sformatf("vec%0d_rdwr", i), {mem_read_o, mem_write_o}, {vecs[i].rd, vecs[i].wr});
      check($sformatf("vec%0d_fv", i), fill_valid_o, vecs[i].fv);
      if (vecs[i].rd || vecs[i].wr)
        check($sformatf("vec%0d_maddr", i), mem_addr_o, vecs[i].maddr);
      tick();
    end
    exp_miss = 1;
    check("clean_fill_data", fill_data_o, FILL_A);
    check("clean_counters", {miss_cnt_o, wb_cnt_o}, {32'd1, 32'd0});
    req_valid_i = 1'b0; mem_resp_i = 1'b0;

    // Hits for 10 cycles: nothing happens.
    req_valid_i = 1'b1; hit_i = 1'b1; dirty_i = 1'b1; addr_i = 32'h0000_7777;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hit_quiet", {stall_o, mem_read_o, mem_write_o, fill_valid_o}, 4'b0000);
      tick();
    end
    check("hit_counters", {miss_cnt_o, wb_cnt_o}, {32'd1, 32'd0});
    req_valid_i = 1'b0; hit_i = 1'b0;

    // Dirty miss: writeback V0..V3 at the victim address, then the fill.
    run_miss(32'h0000_5678, 1'b1, 32'h8000_0040,
             {64'hDEAD_0003, 64'hDEAD_0002, 64'hDEAD_0001, 64'hDEAD_0000},
             {64'hC3, 64'hC2, 64'hC1, 64'hC0}, 0, "dirty");
    check_idle("dirty_after");

    // Wait states between beats; same data as zero-wait.
    run_miss(32'h0000_1234, 1'b0, 32'h0, '0, FILL_A, 3, "wait");
    check_idle("wait_after");
    run_miss(32'h0000_9A00, 1'b1, 32'h4000_01E0,
             {64'h1111_0003, 64'h1111_0002, 64'h1111_0001, 64'h1111_0000},
             {64'hD3, 64'hD2, 64'hD1, 64'hD0}, 3, "waitdirty");
    check_idle("waitdirty_after");

    // Reset during fill beat 2.
    req_valid_i = 1'b1; hit_i = 1'b0; dirty_i = 1'b0; addr_i = 32'h0000_2000;
    tick();
    req_valid_i = 1'b0;
    mem_resp_i = 1'b1; mem_rdata_i = 64'hE0; tick();
    mem_rdata_i = 64'hE1; tick();
    rst = 1'b1; mem_rdata_i = 64'hE2; tick();
    rst = 1'b0; mem_resp_i = 1'b0;
    exp_miss = 0; exp_wb = 0;
    @(negedge clk);
    check("rstmid_ctl", {fill_valid_o, stall_o, mem_read_o, mem_write_o}, 4'b0000);
    check("rstmid_counters", {miss_cnt_o, wb_cnt_o}, 64'h0);
    check("rstmid_fill_data", fill_data_o, '0);
    tick();
    mem_resp_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rstmid_no_fv", {fill_valid_o, mem_read_o}, 2'b00);
      tick();
    end
    mem_resp_i = 1'b0;
    run_miss(32'h0000_3000, 1'b0, 32'h0, '0, {64'hF3, 64'hF2, 64'hF1, 64'hF0}, 1, "postrst");
    check_idle("postrst_after");

    // Back-to-back: second miss in the cycle right after DONE.
    run_miss(32'h0001_0040, 1'b1, 32'h0002_0080,
             {64'h2222_0003, 64'h2222_0002, 64'h2222_0001, 64'h2222_0000},
             {64'h33, 64'h32, 64'h31, 64'h30}, 0, "b2b_first");
    run_miss(32'h0003_00C0, 1'b0, 32'h0, '0,
             {64'h43, 64'h42, 64'h41, 64'h40}, 0, "b2b_second");
    check_idle("b2b_after");
    check("b2b_counters", {miss_cnt_o, wb_cnt_o}, {32'd3, 32'd1});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_miss_ctrl.md
# cache_miss_ctrl

Miss-handling stage directly downstream of the cache's tag-compare/stage-register pipeline. It consumes the registered request (valid, hit, dirty, line address, victim address, victim line). On a miss it stalls the pipeline, writes back the dirty victim line as a beat burst, then fills the requested line from physical memory. It returns the assembled line with a one-cycle `fill_valid_o` strobe for the data-array write.

## Interface
- `LINE_W`, default 256: cache line width in bits.
- `BEAT_W`, default 64: memory beat width; `BEATS = LINE_W/BEAT_W` (4 by default). `LINE_W % BEAT_W == 0` is required.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid_i`  in  1  stage holds a read or write request.
- `hit_i`  in  1  tag compare hit.
- `dirty_i`  in  1  victim way dirty.
- `addr_i`  in  32  request address; bits [4:0] are ignored.
- `wb_addr_i`  in  32  victim line address (tag + set).
- `victim_data_i`  in  LINE_W  victim line contents.
- `stall_o`  out  1  freeze upstream pipeline.
- `fill_valid_o`  out  1  one-cycle strobe: write `fill_data_o` into the array.
- `fill_data_o`  out  LINE_W  assembled fill line.
- `mem_addr_o`  out  32  line-aligned burst address, with [4:0] = 0.
- `mem_read_o`, `mem_write_o`  out  1  burst request, held high for the whole burst.
- `mem_wdata_o`  out  BEAT_W  current writeback beat.
- `mem_rdata_i`  in  BEAT_W  read beat, valid when `mem_resp_i` = 1.
- `mem_resp_i`  in  1  one beat accepted or returned this cycle.
- `miss_cnt_o`, `wb_cnt_o`  out  32  saturating performance counters.

## Operation
- The FSM has four states: IDLE, WB, FILL, DONE.
- **IDLE**
  - Miss = `req_valid_i & ~hit_i`.
  - On a miss, latch `addr_i`, `wb_addr_i`, `victim_data_i` and `dirty_i` into internal registers. Clear the beat counter and increment `miss_cnt_o`.
  - Go to WB if `dirty_i`; otherwise go to FILL.
  - A hit or no request stays in IDLE with no side effects.
- **WB**
  - Drive `mem_write_o` = 1, `mem_addr_o` = {latched wb_addr[31:5], 5'b0}, `mem_wdata_o` = victim[BEAT_W*cnt +: BEAT_W].
  - Each `mem_resp_i` increments `cnt`.
  - On the response with `cnt == BEATS-1`: clear `cnt`, increment `wb_cnt_o`, go to FILL.
- **FILL**
  - Drive `mem_read_o` = 1, `mem_addr_o` = {latched addr[31:5], 5'b0}.
  - Each `mem_resp_i` stores `mem_rdata_i` into `fill_data_o[BEAT_W*cnt +: BEAT_W]` and increments `cnt`.
  - The last beat goes to DONE.
- **DONE**
  - `fill_valid_o` = 1 for exactly one cycle. `fill_data_o` is complete and stays held until the next fill begins.
  - Return to IDLE.
- **Combinational outputs**
  - `stall_o` = (state == WB or FILL) or (state == IDLE and miss). `stall_o` = 0 in DONE, so upstream advances in the same cycle the array is written.
  - The write-miss merge of CPU data is done by the data array, not here.
- **Mem outputs outside a burst:** `mem_read_o` = `mem_write_o` = 0. `mem_addr_o` and `mem_wdata_o` are don't-care but must not contain X.
- **Boundary conditions**
  - `mem_resp_i` in IDLE or DONE is ignored.
  - Input changes after the miss is latched are ignored.
  - Counters saturate at 32'hFFFF_FFFF.
  - A miss presented in the cycle after DONE is a new miss and is handled normally.

## Timing
- **Reset values:** state IDLE, `cnt` 0, `stall_o` 0 (when no request is present), `fill_valid_o` 0, `mem_read_o` 0, `mem_write_o` 0, `fill_data_o` 0, both counters 0.
- **Reset mid-burst:** the cycle after the `rst` edge shows IDLE and all mem requests dropped. Partial fill data is discarded and counters are cleared.
- **Clean-miss latency**
  - The miss is seen in cycle 0 with `stall_o` = 1.
  - `mem_read_o` rises at cycle 1.
  - With zero-wait memory (`mem_resp_i` tied 1), beats arrive in cycles 1–4, DONE is cycle 5 and IDLE is cycle 6.
  - Total stall = 5 cycles (cycles 0–4).
- **Dirty-miss latency:** adds BEATS cycles of WB before FILL. `mem_write_o` falls and `mem_read_o` rises on the same edge, with no idle cycle between them.
- **Memory handshake:** request signals stay constant while waiting for `mem_resp_i`; an arbitrary number of wait cycles between beats is legal.

## Test plan
- **Clean read miss:** `addr_i` = 32'h0000_1234, `dirty_i` = 0, zero-wait memory returning beats 64'hA0..A3 → `mem_addr_o` = 32'h0000_1220; `fill_data_o` = {A3,A2,A1,A0}; `fill_valid_o` high in cycle 5 only; `stall_o` high in cycles 0–4; `miss_cnt_o` = 1, `wb_cnt_o` = 0.
- **Dirty miss:** `wb_addr_i` = 32'h8000_0040, `victim_data_i` beats V0..V3 → four `mem_write_o` beats at 32'h8000_0040 in order V0..V3, then the fill burst at the request address; `wb_cnt_o` = 1.
- **Hit:** `req_valid_i` = 1, `hit_i` = 1 for 10 cycles → `stall_o` = 0, no mem requests, counters unchanged.
- **Wait states:** random 0–3 idle cycles between each `mem_resp_i` → same fill data as the zero-wait case; `mem_addr_o` and `mem_read_o` stable throughout the burst.
- **Reset during FILL beat 2:** → next cycle IDLE, `mem_read_o` = 0, `fill_valid_o` never pulses, counters 0; a subsequent miss completes correctly.
- **Back-to-back misses:** a second miss presented the cycle after DONE → new burst at the new address; `miss_cnt_o` = 2.
